// File: rtl/phy_out_lanes.sv
// Multi-lane fabric-side feeder for per-lane serializers: input FIFO, HOLD/TRAIN/RUN
// sequencing, per-lane word rotation and sticky underrun detection.
module phy_out_lanes #(
    parameter int          LANES           = 4,
    parameter int          DATA_WIDTH      = 8,
    parameter int          FIFO_DEPTH      = 4,
    parameter int          RST_HOLD_CYCLES = 4,
    parameter logic [7:0]  TRAIN_PATTERN   = 8'h5C,
    parameter logic [7:0]  INIT_VALUE      = 8'h00
) (
    input  logic                                   clk_in,
    input  logic                                   reset,
    input  logic [LANES*DATA_WIDTH-1:0]            s_data,
    input  logic                                   s_valid,
    output logic                                   s_ready,
    input  logic                                   train_req,
    input  logic [LANES*$clog2(DATA_WIDTH)-1:0]    rot_sel,
    input  logic                                   underrun_clr,
    output logic [LANES*DATA_WIDTH-1:0]            data_to_serdes,
    output logic                                   serdes_rst,
    output logic [1:0]                             state,
    output logic                                   underrun,
    output logic [$clog2(FIFO_DEPTH):0]            fifo_level
);
    localparam int DW = DATA_WIDTH;
    localparam int RW = $clog2(DATA_WIDTH);
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int LW = PW + 1;
    localparam int WW = LANES * DATA_WIDTH;
    localparam logic [LW-1:0] DEPTH_L   = LW'(FIFO_DEPTH);
    localparam logic [7:0]    HOLD_LAST = 8'(RST_HOLD_CYCLES - 1);

    typedef enum logic [1:0] {ST_HOLD = 2'd0, ST_TRAIN = 2'd1, ST_RUN = 2'd2} state_t;

    state_t          state_q, state_d;
    logic [7:0]      hold_cnt_q, hold_cnt_d;
    logic [WW-1:0]   mem_q [FIFO_DEPTH];
    logic [WW-1:0]   mem_d [FIFO_DEPTH];
    logic [PW-1:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [LW-1:0]   level_q, level_d;
    logic [WW-1:0]   word_q, word_d;
    logic            word_vld_q, word_vld_d;
    logic            popped_q, popped_d;
    logic            underrun_q, underrun_d;
    logic            serdes_rst_q, serdes_rst_d;
    logic [WW-1:0]   dout_q, dout_d;
    logic            push, pop, underrun_set;

    // Output bit i takes word bit (i + r) mod DW; amounts past the lane width wrap once.
    function automatic logic [DW-1:0] rot_word(input logic [DW-1:0] w, input logic [RW-1:0] r);
        int              amt;
        logic [2*DW-1:0] dbl;
        amt = int'(r);
        if (amt >= DW) amt = amt - DW;
        dbl = {w, w} >> amt;
        return dbl[DW-1:0];
    endfunction

    always_comb begin
        state_d    = state_q;
        hold_cnt_d = hold_cnt_q;
        case (state_q)
            ST_HOLD: begin
                if (hold_cnt_q == HOLD_LAST) begin
                    state_d    = ST_TRAIN;
                    hold_cnt_d = '0;
                end else begin
                    hold_cnt_d = hold_cnt_q + 8'd1;
                end
            end
            ST_TRAIN: if (!train_req) state_d = ST_RUN;
            ST_RUN:   if (train_req)  state_d = ST_TRAIN;
            default:  state_d = ST_HOLD;
        endcase
    end

    // Pops stop while a return to TRAIN is requested so the staged word is never dropped.
    always_comb begin
        s_ready  = (state_q != ST_HOLD) && (level_q < DEPTH_L);
        push     = s_valid && s_ready;
        pop      = (state_q == ST_RUN) && !train_req && (level_q != '0);
        mem_d    = mem_q;
        if (push) mem_d[wr_ptr_q] = s_data;
        wr_ptr_d = push ? wr_ptr_q + PW'(1) : wr_ptr_q;
        rd_ptr_d = pop  ? rd_ptr_q + PW'(1) : rd_ptr_q;
        case ({push, pop})
            2'b10:   level_d = level_q + LW'(1);
            2'b01:   level_d = level_q - LW'(1);
            default: level_d = level_q;
        endcase
        word_d     = pop ? mem_q[rd_ptr_q] : word_q;
        word_vld_d = pop;
    end

    always_comb begin
        popped_d     = (state_q == ST_RUN) && (popped_q || pop);
        underrun_set = (state_q == ST_RUN) && !word_vld_q && popped_q;
        if (underrun_set)      underrun_d = 1'b1;
        else if (underrun_clr) underrun_d = 1'b0;
        else                   underrun_d = underrun_q;
        serdes_rst_d = (state_d == ST_HOLD);
        dout_d       = '0;
        for (int l = 0; l < LANES; l++) begin
            case (state_q)
                ST_HOLD:  dout_d[l*DW +: DW] = (state_d == ST_TRAIN)
                                               ? rot_word(TRAIN_PATTERN[DW-1:0], rot_sel[l*RW +: RW])
                                               : INIT_VALUE[DW-1:0];
                ST_TRAIN: dout_d[l*DW +: DW] = rot_word(TRAIN_PATTERN[DW-1:0], rot_sel[l*RW +: RW]);
                ST_RUN:   dout_d[l*DW +: DW] = word_vld_q
                                               ? rot_word(word_q[l*DW +: DW], rot_sel[l*RW +: RW])
                                               : INIT_VALUE[DW-1:0];
                default:  dout_d[l*DW +: DW] = INIT_VALUE[DW-1:0];
            endcase
        end
    end

    always_ff @(posedge clk_in or posedge reset) begin
        if (reset) begin
            state_q      <= ST_HOLD;
            hold_cnt_q   <= '0;
            for (int i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= '0;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            level_q      <= '0;
            word_q       <= '0;
            word_vld_q   <= 1'b0;
            popped_q     <= 1'b0;
            underrun_q   <= 1'b0;
            serdes_rst_q <= 1'b1;
            for (int l = 0; l < LANES; l++) dout_q[l*DW +: DW] <= INIT_VALUE[DW-1:0];
        end else begin
            state_q      <= state_d;
            hold_cnt_q   <= hold_cnt_d;
            mem_q        <= mem_d;
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            level_q      <= level_d;
            word_q       <= word_d;
            word_vld_q   <= word_vld_d;
            popped_q     <= popped_d;
            underrun_q   <= underrun_d;
            serdes_rst_q <= serdes_rst_d;
            dout_q       <= dout_d;
        end
    end

    assign data_to_serdes = dout_q;
    assign serdes_rst     = serdes_rst_q;
    assign state          = state_q;
    assign underrun       = underrun_q;
    assign fifo_level     = level_q;

endmodule

// File: tb/tb_phy_out_lanes.sv
// Directed bench for phy_out_lanes (2 lanes x 8 bits, 4-deep FIFO, 4 hold cycles).
module tb_phy_out_lanes;
    logic        clk_in;
    logic        reset;
    logic [15:0] s_data;
    logic        s_valid;
    logic        s_ready;
    logic        train_req;
    logic [5:0]  rot_sel;
    logic        underrun_clr;
    logic [15:0] data_to_serdes;
    logic        serdes_rst;
    logic [1:0]  state;
    logic        underrun;
    logic [2:0]  fifo_level;

    int n_checks = 0;
    int n_pass   = 0;
    logic [15:0] words [5];

    phy_out_lanes #(
        .LANES(2), .DATA_WIDTH(8), .FIFO_DEPTH(4), .RST_HOLD_CYCLES(4),
        .TRAIN_PATTERN(8'h5C), .INIT_VALUE(8'h00)
    ) dut (
        .clk_in(clk_in), .reset(reset), .s_data(s_data), .s_valid(s_valid),
        .s_ready(s_ready), .train_req(train_req), .rot_sel(rot_sel),
        .underrun_clr(underrun_clr), .data_to_serdes(data_to_serdes),
        .serdes_rst(serdes_rst), .state(state), .underrun(underrun),
        .fifo_level(fifo_level)
    );

    initial clk_in = 1'b0;
    always #5 clk_in = ~clk_in;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        else n_pass++;
    endtask

    task automatic tick();
        @(posedge clk_in);
        @(negedge clk_in);
    endtask

    initial begin
        reset = 1'b0; s_valid = 1'b0; s_data = '0; train_req = 1'b1;
        rot_sel = '0; underrun_clr = 1'b0;
        words[0] = 16'h2211; words[1] = 16'h4433; words[2] = 16'h6655;
        words[3] = 16'h8877; words[4] = 16'hAA99;

        #2 reset = 1'b1;
        #1;
        check("rst_state", state, 0);
        check("rst_srst", serdes_rst, 1);
        check("rst_data", data_to_serdes, 16'h0000);
        check("rst_level", fifo_level, 0);
        check("rst_underrun", underrun, 0);
        check("rst_ready", s_ready, 0);
        @(negedge clk_in);
        @(negedge clk_in);
        reset = 1'b0;

        for (int e = 1; e <= 3; e++) begin
            tick();
            check("hold_state", state, 0);
            check("hold_srst", serdes_rst, 1);
        end
        tick();
        check("train_state", state, 1);
        check("train_srst", serdes_rst, 0);
        check("train_data", data_to_serdes, 16'h5C5C);
        check("train_ready", s_ready, 1);

        rot_sel = {3'd0, 3'd1};
        tick();
        check("rot_lane0_1", data_to_serdes, 16'h5C2E);
        rot_sel = {3'd4, 3'd0};
        tick();
        check("rot_lane1_4", data_to_serdes, 16'hC55C);
        rot_sel = '0;

        for (int k = 0; k < 5; k++) begin
            check("fill_ready", s_ready, (k < 4));
            s_data  = words[k];
            s_valid = 1'b1;
            tick();
            check("fill_level", fifo_level, (k < 4) ? k + 1 : 4);
        end
        check("train_no_pop", data_to_serdes, 16'h5C5C);

        train_req = 1'b0;
        tick();
        check("run_state", state, 2);
        check("run_first_data", data_to_serdes, 16'h5C5C);
        check("run_first_level", fifo_level, 4);
        tick();
        check("stage_gap_data", data_to_serdes, 16'h0000);
        check("pop_level", fifo_level, 3);
        check("pop_ready", s_ready, 1);
        tick();
        check("out_w0", data_to_serdes, 16'h2211);
        check("pushpop_level", fifo_level, 3);
        s_valid = 1'b0;
        tick();
        check("out_w1", data_to_serdes, 16'h4433);
        check("drain_level2", fifo_level, 2);
        tick();
        check("out_w2", data_to_serdes, 16'h6655);
        tick();
        check("out_w3", data_to_serdes, 16'h8877);
        check("drain_level0", fifo_level, 0);
        check("no_underrun_yet", underrun, 0);
        tick();
        check("out_held_w4", data_to_serdes, 16'hAA99);
        check("no_underrun_w4", underrun, 0);
        underrun_clr = 1'b1;
        tick();
        check("underrun_data", data_to_serdes, 16'h0000);
        check("underrun_set_wins", underrun, 1);
        train_req = 1'b1;
        tick();
        check("back_to_train", state, 1);
        check("underrun_still_set", underrun, 1);
        tick();
        check("underrun_cleared", underrun, 0);
        check("retrain_data", data_to_serdes, 16'h5C5C);
        underrun_clr = 1'b0;

        train_req = 1'b0;
        tick();
        tick();
        check("empty_run_data", data_to_serdes, 16'h0000);
        check("empty_run_no_underrun", underrun, 0);
        rot_sel = {3'd0, 3'd4};
        s_valid = 1'b1;
        s_data  = 16'h1357;
        tick();
        check("lat_t_data", data_to_serdes, 16'h0000);
        check("lat_t_level", fifo_level, 1);
        s_data = 16'h2468;
        tick();
        check("lat_t1_data", data_to_serdes, 16'h0000);
        s_data = 16'h9ABC;
        tick();
        check("lat_t2_data", data_to_serdes, 16'h1375);
        s_valid = 1'b0;
        tick();
        check("stream_w1", data_to_serdes, 16'h2486);
        check("stream_level", fifo_level, 0);
        tick();
        check("stream_w2", data_to_serdes, 16'h9ACB);
        check("stream_no_underrun", underrun, 0);
        tick();
        check("stream_underrun_data", data_to_serdes, 16'h0000);
        check("stream_underrun", underrun, 1);
        rot_sel = '0;

        train_req = 1'b1;
        tick();
        s_valid = 1'b1;
        for (int k = 0; k < 3; k++) begin
            s_data = words[k];
            tick();
        end
        s_valid = 1'b0;
        check("pre_reset_level", fifo_level, 3);
        train_req = 1'b0;
        tick();
        check("pre_reset_state", state, 2);
        #2 reset = 1'b1;
        #1;
        check("async_rst_level", fifo_level, 0);
        check("async_rst_state", state, 0);
        check("async_rst_srst", serdes_rst, 1);
        check("async_rst_data", data_to_serdes, 16'h0000);
        check("async_rst_underrun", underrun, 0);
        @(negedge clk_in);
        reset = 1'b0;
        train_req = 1'b1;
        for (int e = 1; e <= 3; e++) tick();
        check("rehold_state", state, 0);
        check("rehold_srst", serdes_rst, 1);
        tick();
        check("retrain_state", state, 1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
